// File: rtl/serial_xfer_sched_if.sv
// Signal bundle between the transfer scheduler, its two requesters and the serial-port bus.
// The scheduler takes the master view. The environment (requesters plus serial port) takes the slave view.
interface serial_xfer_sched_if;
    logic [1:0]  req;
    logic [7:0]  tx_data0;
    logic [7:0]  tx_data1;
    logic [1:0]  int_clk_sel;
    logic [1:0]  ack;
    logic [7:0]  rx_data;
    logic        err;
    logic        busy;
    logic [15:0] addr;
    logic        write;
    logic        read;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        s_interrupt;

    modport master (
        input  req, tx_data0, tx_data1, int_clk_sel, bus_rdata, s_interrupt,
        output ack, rx_data, err, busy, addr, write, read, bus_wdata
    );

    modport slave (
        output req, tx_data0, tx_data1, int_clk_sel, bus_rdata, s_interrupt,
        input  ack, rx_data, err, busy, addr, write, read, bus_wdata
    );
endinterface

// File: rtl/serial_xfer_sched.sv
// Round-robin scheduler for single-byte serial transfers from two requesters.
// Sequence: write SB, start via SC, wait for the interrupt or a timeout, then read SB or abort.
module serial_xfer_sched #(
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd200000
) (
    input logic               clk,
    input logic               reset,
    serial_xfer_sched_if.master bus
);

    typedef enum logic [2:0] {
        StIdle, StWrSb, StWrSc, StWait, StAbort, StRdSb, StDone
    } state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic        r_grant;
    logic        r_last;
    logic        r_sel;
    logic        r_err;
    logic [7:0]  r_tx;
    logic [7:0]  r_rx;
    logic [19:0] r_cnt;
    logic        w_grant;
    logic        w_cnt_term;

    // On contention, favour the requester that was not served last.
    assign w_grant    = (bus.req == 2'b11) ? ~r_last : bus.req[1];
    assign w_cnt_term = (r_cnt == TIMEOUT_CYCLES - 20'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
            r_grant <= 1'b0;
            r_last  <= 1'b1;
            r_sel   <= 1'b0;
            r_err   <= 1'b0;
            r_tx    <= 8'h00;
            r_rx    <= 8'h00;
            r_cnt   <= 20'd0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                StIdle: begin
                    if (|bus.req) begin
                        r_grant <= w_grant;
                        r_last  <= w_grant;
                        r_tx    <= w_grant ? bus.tx_data1 : bus.tx_data0;
                        r_sel   <= bus.int_clk_sel[w_grant];
                    end
                end
                StWrSc: r_cnt <= 20'd0;
                StWait: begin
                    if (r_cnt != 20'hFFFFF) begin
                        r_cnt <= r_cnt + 20'd1;
                    end
                end
                StAbort: begin
                    r_rx  <= 8'hFF;
                    r_err <= 1'b1;
                end
                StRdSb: begin
                    r_rx  <= bus.bus_rdata;
                    r_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_next  = r_state;
        bus.addr      = 16'h0000;
        bus.write     = 1'b0;
        bus.read      = 1'b0;
        bus.bus_wdata = 8'h00;
        bus.ack       = 2'b00;
        case (r_state)
            StIdle: begin
                if (|bus.req) w_state_next = StWrSb;
            end
            StWrSb: begin
                bus.addr      = 16'hFF01;
                bus.write     = 1'b1;
                bus.bus_wdata = r_tx;
                w_state_next  = StWrSc;
            end
            StWrSc: begin
                bus.addr      = 16'hFF02;
                bus.write     = 1'b1;
                bus.bus_wdata = {1'b1, 6'b000000, r_sel};
                w_state_next  = StWait;
            end
            StWait: begin
                // A completion on the terminal cycle wins over the timeout.
                if (bus.s_interrupt) begin
                    w_state_next = StRdSb;
                end else if (w_cnt_term) begin
                    w_state_next = StAbort;
                end
            end
            StAbort: begin
                bus.addr     = 16'hFF02;
                bus.write    = 1'b1;
                w_state_next = StDone;
            end
            StRdSb: begin
                bus.addr     = 16'hFF01;
                bus.read     = 1'b1;
                w_state_next = StDone;
            end
            StDone: begin
                bus.ack      = r_grant ? 2'b10 : 2'b01;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    assign bus.busy    = (r_state != StIdle);
    assign bus.err     = (r_state == StDone) & r_err;
    assign bus.rx_data = r_rx;

endmodule

// File: tb/tb_serial_xfer_sched.sv
// Self-checking bench for serial_xfer_sched: a table of transfers with cycle-exact bus checks.
// A scoreboard checks each ack's rx_data and err, and hand-written sequences cover reset in WAIT.
module tb_serial_xfer_sched;

    localparam int TO = 16;

    logic clk;
    logic reset;

    serial_xfer_sched_if bus ();

    serial_xfer_sched #(
        .TIMEOUT_CYCLES(20'd16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] req;
        logic [7:0] tx0;
        logic [7:0] tx1;
        logic [1:0] sel;
        logic [7:0] rdata;
        int         wait_n;   // cycles in WAIT before s_interrupt; negative = never
        bit         drop;
        logic [1:0] after;
        logic       exp_g;
        logic [7:0] exp_rx;
        logic       exp_err;
    } vec_t;

    typedef struct packed {
        logic [1:0] ack;
        logic [7:0] rx;
        logic       err;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [25:0] bus_vec(input logic w, input logic r, input logic [15:0] a,
                                            input logic [7:0] d);
        return {w, r, a, d};
    endfunction

    // Scoreboard: every ack must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!reset && bus.ack != 2'b00) begin
            exp_t e;
            exp_t got;
            got = '{ack: bus.ack, rx: bus.rx_data, err: bus.err};
            if (sb.size() == 0) begin
                chk("unexpected_ack", {21'd0, got}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_ack_rx_err", {21'd0, got}, {21'd0, e});
            end
        end
    end

    task automatic xfer(input vec_t v, input string nm);
        logic [7:0] exp_sb;
        logic [7:0] exp_sc;
        logic [1:0] onehot;
        exp_sb = v.exp_g ? v.tx1 : v.tx0;
        exp_sc = {1'b1, 6'b000000, v.sel[v.exp_g]};
        onehot = v.exp_g ? 2'b10 : 2'b01;
        @(negedge clk);
        chk($sformatf("%s/idle_busy", nm), {31'd0, bus.busy}, 32'd0);
        bus.req         = v.req;
        bus.tx_data0    = v.tx0;
        bus.tx_data1    = v.tx1;
        bus.int_clk_sel = v.sel;
        bus.bus_rdata   = v.rdata;
        sb.push_back('{ack: onehot, rx: v.exp_rx, err: v.exp_err});
        @(negedge clk);
        chk($sformatf("%s/wr_sb", nm), {6'd0, bus_vec(bus.write, bus.read, bus.addr, bus.bus_wdata)},
            {6'd0, bus_vec(1'b1, 1'b0, 16'hFF01, exp_sb)});
        @(negedge clk);
        chk($sformatf("%s/wr_sc", nm), {6'd0, bus_vec(bus.write, bus.read, bus.addr, bus.bus_wdata)},
            {6'd0, bus_vec(1'b1, 1'b0, 16'hFF02, exp_sc)});
        @(negedge clk);
        chk($sformatf("%s/wait", nm), {5'd0, bus.busy, bus_vec(bus.write, bus.read, bus.addr,
            bus.bus_wdata)}, {5'd0, 1'b1, 26'd0});
        if (v.drop) bus.req[v.exp_g] = 1'b0;
        if (v.wait_n >= 0) begin
            repeat (v.wait_n) @(negedge clk);
            bus.s_interrupt = 1'b1;
            @(negedge clk);
            bus.s_interrupt = 1'b0;
            chk($sformatf("%s/rd_sb", nm), {6'd0, bus_vec(bus.write, bus.read, bus.addr,
                bus.bus_wdata)}, {6'd0, bus_vec(1'b0, 1'b1, 16'hFF01, 8'h00)});
        end else begin
            repeat (TO - 1) @(negedge clk);
            chk($sformatf("%s/wait_last", nm), {6'd0, bus_vec(bus.write, bus.read, bus.addr,
                bus.bus_wdata)}, 32'd0);
            @(negedge clk);
            chk($sformatf("%s/abort", nm), {6'd0, bus_vec(bus.write, bus.read, bus.addr,
                bus.bus_wdata)}, {6'd0, bus_vec(1'b1, 1'b0, 16'hFF02, 8'h00)});
        end
        @(negedge clk);
        chk($sformatf("%s/ack_cycle", nm), {30'd0, bus.ack}, {30'd0, onehot});
        bus.req = v.after;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        bit seen;
        vecs[0] = '{2'b01, 8'hA5, 8'h5A, 2'b01, 8'h3C, 0,  1'b0, 2'b00, 1'b0, 8'h3C, 1'b0};
        vecs[1] = '{2'b10, 8'h11, 8'hC3, 2'b00, 8'h96, 3,  1'b0, 2'b00, 1'b1, 8'h96, 1'b0};
        vecs[2] = '{2'b11, 8'h01, 8'h02, 2'b10, 8'h44, 1,  1'b0, 2'b11, 1'b0, 8'h44, 1'b0};
        vecs[3] = '{2'b11, 8'h01, 8'h02, 2'b10, 8'h55, 2,  1'b0, 2'b00, 1'b1, 8'h55, 1'b0};
        vecs[4] = '{2'b11, 8'h0F, 8'hF0, 2'b11, 8'h66, 0,  1'b0, 2'b00, 1'b0, 8'h66, 1'b0};
        vecs[5] = '{2'b01, 8'h7E, 8'h00, 2'b00, 8'h12, -1, 1'b0, 2'b00, 1'b0, 8'hFF, 1'b1};
        vecs[6] = '{2'b10, 8'h00, 8'hE7, 2'b10, 8'h5A, 15, 1'b0, 2'b00, 1'b1, 8'h5A, 1'b0};
        vecs[7] = '{2'b01, 8'h99, 8'h00, 2'b01, 8'hC0, 4,  1'b1, 2'b00, 1'b0, 8'hC0, 1'b0};

        reset           = 1'b1;
        bus.req         = 2'b00;
        bus.tx_data0    = 8'h00;
        bus.tx_data1    = 8'h00;
        bus.int_clk_sel = 2'b00;
        bus.bus_rdata   = 8'h00;
        bus.s_interrupt = 1'b0;

        @(negedge clk);
        chk("reset_bus", {6'd0, bus_vec(bus.write, bus.read, bus.addr, bus.bus_wdata)}, 32'd0);
        chk("reset_status", {20'd0, bus.busy, bus.err, bus.ack, bus.rx_data}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            xfer(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset while waiting for the interrupt: strobes and busy drop at once, no ack follows.
        @(negedge clk);
        bus.req      = 2'b01;
        bus.tx_data0 = 8'hAA;
        repeat (3) @(negedge clk);
        chk("pre_reset_busy", {31'd0, bus.busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_reset", {5'd0, bus.busy, bus_vec(bus.write, bus.read, bus.addr, bus.bus_wdata)},
            32'd0);
        chk("async_reset_ack", {30'd0, bus.ack}, 32'd0);
        bus.req = 2'b00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        seen  = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.ack != 2'b00 || bus.busy) seen = 1'b1;
        end
        chk("no_ack_after_reset", {31'd0, seen}, 32'd0);
        chk("rx_cleared", {24'd0, bus.rx_data}, 32'd0);

        xfer('{2'b10, 8'h00, 8'h3D, 2'b10, 8'h77, 2, 1'b0, 2'b00, 1'b1, 8'h77, 1'b0}, "post_reset");

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/serial_xfer_sched.md
SERIAL_XFER_SCHED -- requirements
Module: serial_xfer_sched

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 20'd200000: the number of WAIT cycles without s_interrupt before a transfer is aborted.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port req, input, 2 bits: per-requester transfer request, held high until the matching ack.
REQ-005 SHALL have ports tx_data0 and tx_data1, input, 8 bits each: the byte to send for requester 0 and requester 1.
REQ-006 SHALL have port int_clk_sel, input, 2 bits: per requester, 1 = internal shift clock, 0 = external shift clock.
REQ-007 SHALL have port ack, output, 2 bits: one-cycle completion pulse per requester.
REQ-008 SHALL have port rx_data, output, 8 bits: the byte received; valid in the ack cycle and held until the next ack.
REQ-009 SHALL have port err, output, 1 bit: qualifies ack; 1 = transfer timed out.
REQ-010 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 SHALL have port addr, output, 16 bits: bus address driven to the serial port.
REQ-012 SHALL have ports write and read, output, 1 bit each: bus strobes, mutually exclusive.
REQ-013 SHALL have port bus_wdata, output, 8 bits: write data to the serial port din.
REQ-014 SHALL have port bus_rdata, input, 8 bits: read data from the serial port dout, combinational in the same cycle.
REQ-015 SHALL have port s_interrupt, input, 1 bit: the serial transfer-complete pulse.

Function
REQ-016 SHALL implement the FSM states IDLE, WR_SB, WR_SC, WAIT, ABORT, RD_SB and DONE.
REQ-017 In IDLE with any req bit high, SHALL latch grant index g, that requester's tx byte and its clock-select bit, then go to WR_SB on the next cycle.
REQ-018 SHALL arbitrate round-robin:
- if both req bits are high, grant the index not granted last;
- after reset, requester 0 wins first.
REQ-019 In WR_SB, SHALL drive addr=16'hFF01, write=1 and bus_wdata=latched tx byte for exactly one cycle, then go to WR_SC.
REQ-020 In WR_SC, SHALL drive addr=16'hFF02, write=1 and bus_wdata={1'b1,6'b0,latched int_clk_sel} for one cycle, then go to WAIT.
REQ-021 In WAIT, SHALL drive no strobe and SHALL increment the timeout counter each cycle; the counter clears on entry.
REQ-022 In WAIT, s_interrupt=1 SHALL cause a move to RD_SB on the next cycle.
REQ-023 When the counter reaches TIMEOUT_CYCLES-1 with s_interrupt=0, SHALL go to ABORT.
REQ-024 If s_interrupt and the timeout terminal count coincide, SHALL treat the transfer as completed (RD_SB) and not as aborted.
REQ-025 In ABORT, SHALL drive addr=16'hFF02, write=1 and bus_wdata=8'h00 for one cycle, then go to DONE with err=1 and rx_data=8'hFF.
REQ-026 In RD_SB, SHALL drive addr=16'hFF01 and read=1 for one cycle, capture bus_rdata into rx_data, then go to DONE with err=0.
REQ-027 In DONE, SHALL pulse ack[g]=1 for one cycle and return to IDLE; a new grant is possible the following cycle.
REQ-028 SHALL have latency, with req sampled in IDLE at cycle N: WR_SB at N+1, WR_SC at N+2, WAIT from N+3.
REQ-029 SHALL have latency, with s_interrupt seen at cycle M: RD_SB at M+1, ack at M+2.
REQ-030 In every state without a strobe, SHALL drive addr=16'h0000, bus_wdata=8'h00, write=0 and read=0.
REQ-031 If req[g] drops mid-transfer, SHALL still complete the transfer and pulse ack[g].
REQ-032 A req bit raised and dropped while the FSM is not in IDLE SHALL be ignored.
REQ-033 SHALL never pulse both ack bits in the same cycle.
REQ-034 SHALL saturate the timeout counter; it never wraps.

Reset
REQ-035 While reset=1, SHALL force asynchronously: state=IDLE, write=0, read=0, addr=0, bus_wdata=0, ack=0, err=0, busy=0, rx_data=8'h00, timeout counter=0, round-robin pointer so that requester 0 wins first.
REQ-036 On reset mid-transfer, SHALL drop strobes immediately, produce no ack, and clear all latched request state.

Verification
REQ-037 Bench SHALL cover: req=2'b01, tx_data0=8'hA5, int_clk_sel[0]=1 -> write FF01/A5 at N+1, write FF02/81 at N+2; s_interrupt at M with bus_rdata=8'h3C -> read FF01 at M+1, ack=2'b01, rx_data=3C, err=0 at M+2.
REQ-038 Bench SHALL cover: req=2'b11 held for two transfers -> grants in order 0, 1; then with req=2'b11 again -> grant 0.
REQ-039 Bench SHALL cover: TIMEOUT_CYCLES=16 with no s_interrupt -> write FF02/00 at cycle N+3+15+1, then ack with err=1 and rx_data=FF.
REQ-040 Bench SHALL cover: TIMEOUT_CYCLES=16 with s_interrupt on the terminal cycle -> RD_SB path, err=0.
REQ-041 Bench SHALL cover: reset asserted in WAIT -> busy=0, strobes=0 in the same cycle; no ack after release; next req=2'b10 is granted to requester 1 normally.
REQ-042 Bench SHALL cover: req[0] dropped in WAIT -> ack[0] still pulses after s_interrupt.
